// File: rtl/win_nav.sv
// win_nav: window-origin and edit-cursor navigator for the 128x128 toroidal
// Life world, with keyboard auto-repeat on the arrow keys.
module win_nav #(
    parameter int unsigned REPEAT_DELAY  = 12_500_000,
    parameter int unsigned REPEAT_PERIOD = 2_500_000,
    parameter int unsigned CNT_W         = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  win_ctrl_cmd,
    input  logic [7:0]  view_width,
    output logic [6:0]  org_x,
    output logic [6:0]  org_y,
    output logic [6:0]  cur_x,
    output logic [6:0]  cur_y,
    output logic [13:0] cur_addr,
    output logic        moved
);

    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       r_prev_a;
    logic [7:0]       r_prev_width;

    logic [3:0] w_a;
    logic       w_any;
    logic       w_chg;
    logic       w_step;
    logic       w_up, w_down, w_left, w_right;
    logic       w_mode;
    logic       w_wchg;
    logic       w_fix;
    logic [7:0] w_width;
    logic [6:0] w_dx, w_dy;
    logic [6:0] w_cur_x_s, w_cur_y_s, w_org_x_s, w_org_y_s;
    logic [6:0] w_org_x_n, w_org_y_n;
    logic       w_unused;

    assign w_a      = win_ctrl_cmd[3:0];
    assign w_up     = win_ctrl_cmd[0];
    assign w_down   = win_ctrl_cmd[1];
    assign w_left   = win_ctrl_cmd[2];
    assign w_right  = win_ctrl_cmd[3];
    assign w_mode   = win_ctrl_cmd[6];
    assign w_unused = ^win_ctrl_cmd[5:4];
    assign w_any    = |w_a;
    assign w_chg    = (w_a != r_prev_a);
    assign w_wchg   = (view_width != r_prev_width);
    assign w_width  = (view_width == 8'd0) ? 8'd1 : view_width;
    assign cur_addr = {cur_y, cur_x};

    // Pull the origin back so the cursor is inside a W-wide window on one axis.
    function automatic logic [6:0] fix_org(input logic [6:0] org, input logic [6:0] cur,
                                           input logic plus, input logic [7:0] w);
        logic [6:0] off;
        off = cur - org;
        if (!w[7] && ({1'b0, off} >= w))
            fix_org = plus ? (cur - w[6:0] + 7'd1) : cur;
        else
            fix_org = org;
    endfunction

    // Repeat FSM state register and counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Repeat FSM next state: any new arrow pattern restarts the delay phase.
    always_comb begin
        w_state_nxt = r_state;
        if (!w_any)
            w_state_nxt = S_IDLE;
        else if (w_chg || (r_state == S_IDLE))
            w_state_nxt = S_DELAY;
        else if ((r_state == S_DELAY) && (r_cnt == DLY_LAST))
            w_state_nxt = S_REPEAT;
    end

    // Repeat FSM outputs: step strobe and counter update.
    always_comb begin
        w_step    = 1'b0;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (!w_any) begin
            w_cnt_nxt = '0;
        end else if (w_chg || (r_state == S_IDLE)) begin
            w_step    = 1'b1;
            w_cnt_nxt = '0;
        end else if ((r_state == S_DELAY) && (r_cnt == DLY_LAST)) begin
            w_step    = 1'b1;
            w_cnt_nxt = '0;
        end else if ((r_state == S_REPEAT) && (r_cnt == RPT_LAST)) begin
            w_step    = 1'b1;
            w_cnt_nxt = '0;
        end
    end

    // Position datapath: apply the step, then re-establish cursor visibility.
    always_comb begin
        w_dx = 7'd0;
        w_dy = 7'd0;
        if (w_step) begin
            if (w_right && !w_left)      w_dx = 7'd1;
            else if (w_left && !w_right) w_dx = 7'h7F;
            if (w_down && !w_up)         w_dy = 7'd1;
            else if (w_up && !w_down)    w_dy = 7'h7F;
        end
        w_cur_x_s = cur_x + w_dx;
        w_cur_y_s = cur_y + w_dy;
        w_org_x_s = w_mode ? (org_x + w_dx) : org_x;
        w_org_y_s = w_mode ? (org_y + w_dy) : org_y;
        w_fix     = (w_step && !w_mode) || w_wchg;
        w_org_x_n = w_org_x_s;
        w_org_y_n = w_org_y_s;
        if (w_fix) begin
            w_org_x_n = fix_org(w_org_x_s, w_cur_x_s, (w_dx == 7'd1), w_width);
            w_org_y_n = fix_org(w_org_y_s, w_cur_y_s, (w_dy == 7'd1), w_width);
        end
    end

    // Position, history and moved-pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            org_x        <= 7'd0;
            org_y        <= 7'd0;
            cur_x        <= 7'd0;
            cur_y        <= 7'd0;
            moved        <= 1'b0;
            r_prev_a     <= 4'd0;
            r_prev_width <= 8'd8;
        end else begin
            org_x        <= w_org_x_n;
            org_y        <= w_org_y_n;
            cur_x        <= w_cur_x_s;
            cur_y        <= w_cur_y_s;
            moved        <= (w_org_x_n != org_x) || (w_org_y_n != org_y) ||
                            (w_cur_x_s != cur_x) || (w_cur_y_s != cur_y);
            r_prev_a     <= w_a;
            r_prev_width <= view_width;
        end
    end

endmodule

// File: tb/tb_win_nav.sv
// Testbench for win_nav: directed scenarios plus randomized traffic against a
// time-since-press reference model.
module tb_win_nav;

    localparam int D = 4;
    localparam int P = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  cmd = 7'd0;
    logic [7:0]  vw  = 8'd8;
    logic [6:0]  org_x, org_y, cur_x, cur_y;
    logic [13:0] cur_addr;
    logic        moved;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_ox, m_oy, m_cx, m_cy;
    int m_moved;
    int m_prev_a;
    int m_prev_w;
    int m_t;          // edges since the current arrow pattern began, -1 when idle

    win_nav #(.REPEAT_DELAY(D), .REPEAT_PERIOD(P), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .win_ctrl_cmd(cmd), .view_width(vw),
        .org_x(org_x), .org_y(org_y), .cur_x(cur_x), .cur_y(cur_y),
        .cur_addr(cur_addr), .moved(moved)
    );

    always #5 clk = ~clk;

    function automatic int fixo(int o, int c, int plus, int w);
        int off;
        off = (c - o) & 127;
        if (w < 128 && off >= w) return plus ? ((c - w + 1) & 127) : c;
        return o;
    endfunction

    task automatic model_edge();
        int a, step, dx, dy, w, mode, nox, noy, ncx, ncy;
        if (rst) begin
            m_ox = 0; m_oy = 0; m_cx = 0; m_cy = 0; m_moved = 0;
            m_prev_a = 0; m_prev_w = 8; m_t = -1;
            return;
        end
        a = int'(cmd[3:0]);
        mode = int'(cmd[6]);
        step = 0;
        if (a == 0) m_t = -1;
        else if (a != m_prev_a || m_t < 0) begin m_t = 0; step = 1; end
        else begin
            m_t++;
            step = (m_t == D) || (m_t > D && ((m_t - D) % P) == 0);
        end
        dx = 0; dy = 0;
        if (step) begin
            dx = (cmd[3] && !cmd[2]) ? 1 : (cmd[2] && !cmd[3]) ? -1 : 0;
            dy = (cmd[1] && !cmd[0]) ? 1 : (cmd[0] && !cmd[1]) ? -1 : 0;
        end
        w = (vw == 0) ? 1 : int'(vw);
        ncx = (m_cx + dx) & 127;
        ncy = (m_cy + dy) & 127;
        nox = mode ? ((m_ox + dx) & 127) : m_ox;
        noy = mode ? ((m_oy + dy) & 127) : m_oy;
        if ((step && !mode) || int'(vw) != m_prev_w) begin
            nox = fixo(nox, ncx, dx == 1, w);
            noy = fixo(noy, ncy, dy == 1, w);
        end
        m_moved = (nox != m_ox) || (noy != m_oy) || (ncx != m_cx) || (ncy != m_cy);
        m_ox = nox; m_oy = noy; m_cx = ncx; m_cy = ncy;
        m_prev_a = a;
        m_prev_w = int'(vw);
    endtask

    function automatic logic [42:0] dut_vec();
        return {org_x, org_y, cur_x, cur_y, cur_addr, moved};
    endfunction

    function automatic logic [42:0] exp_vec();
        return {7'(m_ox), 7'(m_oy), 7'(m_cx), 7'(m_cy), 7'(m_cy), 7'(m_cx), 1'(m_moved)};
    endfunction

    // one clock edge; model advances with the inputs seen at that edge
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic go_reset();
        rst = 1'b1; cmd = 7'd0; vw = 8'd8;
        tick();
        rst = 1'b0;
    endtask

    // press for one edge, release for one edge
    task automatic pulse(input logic [6:0] c);
        cmd = c;    tick();
        cmd = {c[6], 6'd0}; tick();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            rst = 1'b1; cmd = 7'($urandom_range(0, 127)); vw = 8'd8;
            tick();
            checks++;
            if (dut_vec() !== 43'd0) begin
                errors++;
                $display("FAIL reset edge %0d: got %h want 0", i, dut_vec());
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_hold_right();
        int pulses = 0;
        go_reset();
        cmd = 7'b000_1000;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (moved === 1'b1) pulses++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL hold_right edge %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        cmd = 7'd0; tick();
        checks++;
        if (pulses != 4 || cur_x !== 7'd4 || org_x !== 7'd0) begin
            errors++;
            $display("FAIL hold_right_total: pulses=%0d cur_x=%0d org_x=%0d want 4 4 0", pulses, cur_x, org_x);
        end
    endtask

    task automatic test_cursor_wrap();
        go_reset();
        for (int i = 0; i < 7; i++) pulse(7'b000_1000);
        checks++;
        if (cur_x !== 7'd7 || org_x !== 7'd0) begin
            errors++;
            $display("FAIL right_setup: cur_x=%0d org_x=%0d want 7 0", cur_x, org_x);
        end
        cmd = 7'b000_1000; tick();
        checks++;
        if (cur_x !== 7'd8 || org_x !== 7'd1 || moved !== 1'b1) begin
            errors++;
            $display("FAIL right_scroll: cur_x=%0d org_x=%0d moved=%b want 8 1 1", cur_x, org_x, moved);
        end
        cmd = 7'd0; tick();
        go_reset();
        cmd = 7'b000_0100; tick();
        checks++;
        if (cur_x !== 7'd127 || org_x !== 7'd127 || cur_addr !== 14'h007F) begin
            errors++;
            $display("FAIL left_wrap: cur_x=%0d org_x=%0d addr=%h want 127 127 007f", cur_x, org_x, cur_addr);
        end
        cmd = 7'd0; tick();
    endtask

    task automatic test_window();
        int saw_moved = 0;
        go_reset();
        for (int i = 0; i < 3; i++) pulse(7'b000_0010);
        cmd = 7'b100_0001; tick();
        checks++;
        if (org_y !== 7'd127 || cur_y !== 7'd2) begin
            errors++;
            $display("FAIL window_up: org_y=%0d cur_y=%0d want 127 2", org_y, cur_y);
        end
        cmd = 7'b100_0000; tick();
        cmd = 7'b100_1001; tick();
        checks++;
        if (org_y !== 7'd126 || cur_y !== 7'd1 || org_x !== 7'd1 || cur_x !== 7'd1) begin
            errors++;
            $display("FAIL window_diag: org=(%0d,%0d) cur=(%0d,%0d) want (1,126) (1,1)", org_x, org_y, cur_x, cur_y);
        end
        cmd = 7'b100_0000; tick();
        cmd = 7'b100_1100;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (moved !== 1'b0) saw_moved++;
        end
        checks++;
        if (saw_moved != 0 || org_x !== 7'd1 || cur_x !== 7'd1) begin
            errors++;
            $display("FAIL cancel_pair: moved_cycles=%0d org_x=%0d cur_x=%0d want 0 1 1", saw_moved, org_x, cur_x);
        end
        cmd = 7'd0; tick();
    endtask

    task automatic test_width_change();
        go_reset();
        vw = 8'd32;
        for (int i = 0; i < 20; i++) pulse(7'b000_1000);
        checks++;
        if (cur_x !== 7'd20 || org_x !== 7'd0) begin
            errors++;
            $display("FAIL width_setup: cur_x=%0d org_x=%0d want 20 0", cur_x, org_x);
        end
        vw = 8'd16; tick();
        checks++;
        if (org_x !== 7'd20 || moved !== 1'b1) begin
            errors++;
            $display("FAIL width_shrink: org_x=%0d moved=%b want 20 1", org_x, moved);
        end
        vw = 8'd128; tick(); tick();
        checks++;
        if (org_x !== 7'd20 || cur_x !== 7'd20) begin
            errors++;
            $display("FAIL width_full: org_x=%0d cur_x=%0d want 20 20", org_x, cur_x);
        end
        vw = 8'd8; tick();
    endtask

    task automatic test_reset_mid_repeat();
        go_reset();
        cmd = 7'b000_0010;
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if (cur_y !== 7'd0 || moved !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: cur_y=%0d moved=%b want 0 0", cur_y, moved);
        end
        for (int j = 0; j <= D; j++) begin
            tick();
            checks++;
            if (cur_y !== ((j < D) ? 7'd1 : 7'd2) || dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL after_reset edge %0d: cur_y=%0d got %h want %h", j, cur_y, dut_vec(), exp_vec());
            end
        end
        cmd = 7'd0; tick();
    endtask

    task automatic test_random();
        go_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                cmd = 7'($urandom_range(0, 127));
                if ($urandom_range(0, 2) == 0) cmd[3:0] = 4'd0;
            end
            if ($urandom_range(0, 24) == 0)
                vw = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'(1 << $urandom_range(0, 7));
            rst = ($urandom_range(0, 149) == 0);
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random edge %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        m_ox = 0; m_oy = 0; m_cx = 0; m_cy = 0; m_moved = 0;
        m_prev_a = 0; m_prev_w = 8; m_t = -1;
        #2;
        test_reset();
        test_hold_right();
        test_cursor_wrap();
        test_window();
        test_width_change();
        test_reset_mid_repeat();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
